asrv32_wb_arbiter: RTL and testbench

Two-master to one-slave Wishbone (classic, single outstanding transfer) arbiter.
It shares the core's single memory port between the fetch stage (instruction requester, IF) and the memory stage (data load/store requester, MEM).
It owns request capture, grant sequencing, round-robin fairness, response routing and abort of stale instruction fetches after PC redirects.

---
 rtl/asrv32_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_asrv32_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/asrv32_wb_arbiter.sv
// IF/MEM to single classic-Wishbone slave arbiter: round-robin on ties, bus cycle starts the edge after a
// request is seen in IDLE, acks are combinational; losers wait while holding stb. Timeout: ASRV32_WB_ARB_TIMEOUT_EN.
module asrv32_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stb_inst,
    input  logic [31:0] i_inst_addr,
    input  logic        i_inst_abort,
    output logic [31:0] o_inst,
    output logic        o_ack_inst,
    output logic        o_err_inst,
    input  logic        i_stb_data,
    input  logic        i_we_data,
    input  logic [3:0]  i_sel_data,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_store,
    output logic [31:0] o_data_load,
    output logic        o_ack_data,
    output logic        o_err_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack,
    output logic        o_busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_I = 2'd1;
    localparam logic [1:0] S_GNT_D = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        last_inst_q, last_inst_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        timeout;
    logic        pick_data;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("asrv32_wb_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    // Data wins when alone or when instruction was served last.
    assign pick_data = i_stb_data & (~i_stb_inst | last_inst_q);

    always_comb begin
        state_d     = state_q;
        last_inst_d = last_inst_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        case (state_q)
            S_IDLE: begin
                if (pick_data) begin
                    state_d     = S_GNT_D;
                    last_inst_d = 1'b0;
                    cyc_d       = 1'b1;
                    we_d        = i_we_data;
                    sel_d       = i_sel_data;
                    addr_d      = i_data_addr;
                    wdat_d      = i_data_store;
                end else if (i_stb_inst) begin
                    state_d     = S_GNT_I;
                    last_inst_d = 1'b1;
                    cyc_d       = 1'b1;
                    we_d        = 1'b0;
                    sel_d       = 4'hF;
                    addr_d      = i_inst_addr;
                end
            end
            S_GNT_I: begin
                if (i_inst_abort || i_wb_ack || timeout) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                end
            end
            S_GNT_D: begin
                if (i_wb_ack || timeout) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            last_inst_q <= 1'b1;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            addr_q      <= 32'h0;
            wdat_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            last_inst_q <= last_inst_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
        end
    end

`ifdef ASRV32_WB_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_inst_q;
    logic             err_data_q;

    // Ack beats timeout; an abort ends the fetch without an error.
    assign timeout = (state_q != S_IDLE) && !i_wb_ack
                   && !((state_q == S_GNT_I) && i_inst_abort) && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            err_inst_q <= 1'b0;
            err_data_q <= 1'b0;
        end else begin
            cnt_q      <= (state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
            err_inst_q <= timeout && (state_q == S_GNT_I);
            err_data_q <= timeout && (state_q == S_GNT_D);
        end
    end

    assign o_err_inst = err_inst_q;
    assign o_err_data = err_data_q;
`else
    assign timeout    = 1'b0;
    assign o_err_inst = 1'b0;
    assign o_err_data = 1'b0;
`endif

    assign o_ack_inst  = (state_q == S_GNT_I) & i_wb_ack & ~i_inst_abort;
    assign o_ack_data  = (state_q == S_GNT_D) & i_wb_ack;
    assign o_inst      = i_wb_data;
    assign o_data_load = i_wb_data;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;
    assign o_wb_we     = we_q;
    assign o_wb_sel    = sel_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = wdat_q;
    assign o_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_asrv32_wb_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level owner/round-robin model.
module tb_asrv32_wb_arbiter;
`ifdef ASRV32_WB_ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_stb_inst, i_inst_abort, i_stb_data, i_we_data, i_wb_ack;
    logic [31:0] i_inst_addr, i_data_addr, i_data_store, i_wb_data;
    logic [3:0]  i_sel_data;
    logic [31:0] o_inst, o_data_load, o_wb_addr, o_wb_data;
    logic        o_ack_inst, o_err_inst, o_ack_data, o_err_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we, o_busy;
    logic [3:0]  o_wb_sel;

    int checks = 0;
    int failures = 0;

    // Reference model: who owns the bus, who was served last, what was captured.
    int          own;       // 0 none, 1 instruction, 2 data
    bit          last_i;
    bit          done_i, done_d, take_d, fa;
    int          own_cyc;
    logic [31:0] e_addr, e_dat;
    logic        e_we;
    logic [3:0]  e_sel;

    asrv32_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_stb_inst(i_stb_inst), .i_inst_addr(i_inst_addr), .i_inst_abort(i_inst_abort),
        .o_inst(o_inst), .o_ack_inst(o_ack_inst), .o_err_inst(o_err_inst),
        .i_stb_data(i_stb_data), .i_we_data(i_we_data), .i_sel_data(i_sel_data),
        .i_data_addr(i_data_addr), .i_data_store(i_data_store),
        .o_data_load(o_data_load), .o_ack_data(o_ack_data), .o_err_data(o_err_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .i_wb_data(i_wb_data),
        .i_wb_ack(i_wb_ack), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic cyc, input logic we,
                           input logic [3:0] sel, input logic [31:0] addr);
        chk({tag, "_cyc"}, o_wb_cyc, cyc);
        chk({tag, "_stb"}, o_wb_stb, cyc);
        chk({tag, "_we"}, o_wb_we, we);
        chk({tag, "_sel"}, o_wb_sel, sel);
        chk({tag, "_addr"}, o_wb_addr, addr);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_stb_inst = 0; i_inst_abort = 0; i_stb_data = 0; i_we_data = 0; i_wb_ack = 0;
        i_inst_addr = 0; i_data_addr = 0; i_data_store = 0; i_wb_data = 0; i_sel_data = 0;
        #12;
        chk_bus("rst0", 1'b0, 1'b0, 4'h0, 32'h0);
        chk("rst0_busy", o_busy, 1'b0);
        chk("rst0_data", o_wb_data, 32'h0);

        // 1: reset in the middle of a pending store, then data wins the first tie
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_stb_data = 1; i_we_data = 1; i_sel_data = 4'hF;
        i_data_addr = 32'h3000; i_data_store = 32'h1234;
        tick();
        chk_bus("st_gnt", 1'b1, 1'b1, 4'hF, 32'h3000);
        #3 i_rst_n = 1'b0;
        #1;
        chk_bus("async_rst", 1'b0, 1'b0, 4'h0, 32'h0);
        chk("async_rst_data", o_wb_data, 32'h0);
        chk("async_rst_busy", o_busy, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_stb_inst = 1; i_inst_addr = 32'h100;
        tick();
        chk_bus("first_tie", 1'b1, 1'b1, 4'hF, 32'h3000);
        chk("first_tie_wdat", o_wb_data, 32'h1234);
        i_wb_ack = 1;
        #1;
        chk("first_ackd", o_ack_data, 1'b1);
        chk("first_acki", o_ack_inst, 1'b0);
        tick();
        i_wb_ack = 0; i_stb_data = 0;
        chk("ack_drop_cyc", o_wb_cyc, 1'b0);

        // 2: instruction fetch, combinational ack and data
        tick();
        chk_bus("if_gnt", 1'b1, 1'b0, 4'hF, 32'h100);
        i_wb_ack = 1; i_wb_data = 32'h13;
        #1;
        chk("if_ack", o_ack_inst, 1'b1);
        chk("if_data", o_inst, 32'h13);
        chk("if_ackd", o_ack_data, 1'b0);
        tick();
        i_wb_ack = 0; i_stb_inst = 0;
        chk("if_done_busy", o_busy, 1'b0);

        // 3: both held, grants alternate starting with data
        i_stb_inst = 1; i_stb_data = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_bus("rr_gnt", 1'b1, (i % 2 == 0), 4'hF, (i % 2 == 0) ? 32'h3000 : 32'h100);
            i_wb_ack = 1;
            #1;
            chk("rr_ackd", o_ack_data, (i % 2 == 0));
            chk("rr_acki", o_ack_inst, (i % 2 != 0));
            tick();
            i_wb_ack = 0;
            chk("rr_idle", o_wb_cyc, 1'b0);
        end
        i_stb_inst = 0; i_stb_data = 0;

        // 4: store arriving during an instruction transfer waits for its ack
        i_stb_inst = 1; i_inst_addr = 32'h200;
        tick();
        i_stb_data = 1; i_we_data = 1; i_data_addr = 32'h2000;
        i_sel_data = 4'b0011; i_data_store = 32'hDEADBEEF;
        tick();
        tick();
        chk_bus("wait_st", 1'b1, 1'b0, 4'hF, 32'h200);
        i_wb_ack = 1;
        #1;
        chk("wait_acki", o_ack_inst, 1'b1);
        tick();
        i_wb_ack = 0; i_stb_inst = 0;
        chk("wait_gap", o_wb_cyc, 1'b0);
        tick();
        chk_bus("st_after", 1'b1, 1'b1, 4'h3, 32'h2000);
        chk("st_after_dat", o_wb_data, 32'hDEADBEEF);
        i_wb_ack = 1;
        tick();
        i_wb_ack = 0; i_stb_data = 0;

        // 5: abort together with ack suppresses the fetch ack
        i_stb_inst = 1; i_inst_addr = 32'h300;
        tick();
        i_wb_ack = 1; i_inst_abort = 1; i_wb_data = 32'h55;
        #1;
        chk("abort_noack", o_ack_inst, 1'b0);
        tick();
        i_wb_ack = 0; i_inst_abort = 0; i_stb_inst = 0;
        chk("abort_cyc", o_wb_cyc, 1'b0);
        chk("abort_busy", o_busy, 1'b0);

        // abort cannot cancel a data transfer
        i_stb_data = 1; i_we_data = 0; i_data_addr = 32'h400;
        tick();
        i_inst_abort = 1;
        tick();
        i_inst_abort = 0;
        chk_bus("dabort", 1'b1, 1'b0, i_sel_data, 32'h400);
        i_wb_ack = 1;
        #1;
        chk("dabort_ack", o_ack_data, 1'b1);
        tick();
        i_wb_ack = 0; i_stb_data = 0;

        // stray ack in IDLE
        i_wb_ack = 1;
        #1;
        chk("idle_acki", o_ack_inst, 1'b0);
        chk("idle_ackd", o_ack_data, 1'b0);
        tick();
        i_wb_ack = 0;
        chk("idle_cyc", o_wb_cyc, 1'b0);

`ifdef ASRV32_WB_ARB_TIMEOUT_EN
        // 6: load never acked times out after 4 cycles, pending fetch goes next
        i_stb_data = 1; i_we_data = 0; i_data_addr = 32'h500;
        tick();
        i_stb_inst = 1; i_inst_addr = 32'h600;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("to_wait_cyc", o_wb_cyc, 1'b1);
            chk("to_wait_err", o_err_data, 1'b0);
        end
        tick();
        chk("to_cyc", o_wb_cyc, 1'b0);
        chk("to_errd", o_err_data, 1'b1);
        chk("to_erri", o_err_inst, 1'b0);
        i_stb_data = 0;
        tick();
        chk("to_err_pulse", o_err_data, 1'b0);
        chk_bus("to_next", 1'b1, 1'b0, 4'hF, 32'h600);
        i_wb_ack = 1;
        tick();
        i_wb_ack = 0; i_stb_inst = 0;
`endif

        // randomized run from a fresh reset
        i_rst_n = 1'b0;
        #2;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        own = 0; last_i = 1; done_i = 0; done_d = 0; own_cyc = 0;
        e_addr = 0; e_dat = 0; e_we = 0; e_sel = 0;
        for (int n = 0; n < 3000; n++) begin
            if (done_i) begin
                done_i = 0;
                if ($urandom_range(0, 1) == 1) i_stb_inst = 0;
                else i_inst_addr = $urandom;
            end else if (!i_stb_inst && $urandom_range(0, 2) == 0) begin
                i_stb_inst = 1; i_inst_addr = $urandom;
            end
            if (done_d || (!i_stb_data && $urandom_range(0, 2) == 0)) begin
                if (done_d && $urandom_range(0, 1) == 1) i_stb_data = 0;
                else begin
                    i_stb_data = 1; i_we_data = 1'($urandom_range(0, 1));
                    i_sel_data = 4'($urandom_range(0, 15));
                    i_data_addr = $urandom; i_data_store = $urandom;
                end
                done_d = 0;
            end
            fa = 0;
`ifdef ASRV32_WB_ARB_TIMEOUT_EN
            fa = (own != 0) && (own_cyc >= 2);
`endif
            i_wb_ack = (own != 0) ? (fa || $urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            i_inst_abort = ($urandom_range(0, 7) == 0);
            i_wb_data = $urandom;
            @(negedge i_clk);
            chk("r_cyc", o_wb_cyc, own != 0);
            chk("r_stb", o_wb_stb, own != 0);
            chk("r_busy", o_busy, own != 0);
            if (own != 0) begin
                chk("r_addr", o_wb_addr, e_addr);
                chk("r_we", o_wb_we, e_we);
                chk("r_sel", o_wb_sel, e_sel);
                if (own == 2 && e_we) chk("r_wdat", o_wb_data, e_dat);
            end
            chk("r_acki", o_ack_inst, own == 1 && i_wb_ack && !i_inst_abort);
            chk("r_ackd", o_ack_data, own == 2 && i_wb_ack);
            chk("r_err", {o_err_inst, o_err_data}, 2'b00);
            if (n % 16 == 0) begin
                chk("r_inst", o_inst, i_wb_data);
                chk("r_load", o_data_load, i_wb_data);
            end
            if (own == 0) begin
                if (i_stb_inst || i_stb_data) begin
                    take_d = i_stb_data && (!i_stb_inst || last_i);
                    own = take_d ? 2 : 1;
                    last_i = !take_d;
                    own_cyc = 0;
                    e_addr = take_d ? i_data_addr : i_inst_addr;
                    e_we = take_d ? i_we_data : 1'b0;
                    e_sel = take_d ? i_sel_data : 4'hF;
                    e_dat = i_data_store;
                end
            end else if (own == 1) begin
                if (i_inst_abort || i_wb_ack) begin own = 0; done_i = 1; end
                else own_cyc++;
            end else begin
                if (i_wb_ack) begin own = 0; done_d = 1; end
                else own_cyc++;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
